// File: rtl/hist_pkg.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// hist_pkg
// Shared definitions for the histogram run controller.
//   - hist_state_e  : run-controller state encoding
//   - RAM_* params  : field positions inside a 32-bit AXI RAM write word
//                     {8'h0, addr[7:0], 8'h0, data[7:0]}
//   - HIST_NUM_BINS : number of histogram bins
//   - pack_ram_word : builds a RAM write word from an address and a data byte
// ---------------------------------------------------------------------------
package hist_pkg;

    localparam int HIST_NUM_BINS = 8;

    localparam int RAM_FIELD_W  = 8;
    localparam int RAM_ADDR_LSB = 16;
    localparam int RAM_DATA_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } hist_state_e;

    function automatic logic [31:0] pack_ram_word(input logic [RAM_FIELD_W-1:0] addr,
                                                  input logic [RAM_FIELD_W-1:0] data);
        logic [31:0] word;
        word = '0;
        word[RAM_ADDR_LSB +: RAM_FIELD_W] = addr;
        word[RAM_DATA_LSB +: RAM_FIELD_W] = data;
        return word;
    endfunction

endpackage

// File: rtl/axis_mux2.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// axis_mux2
// Two-input AXI-Stream selector onto one sink.
//   en      : when low the sink sees no valid and neither source sees ready
//   sel     : 0 selects source 0, 1 selects source 1
//   s0_*    : source 0 (tdata/tvalid in, tready out)
//   s1_*    : source 1 (tdata/tvalid in, tready out)
//   m_*     : sink (tdata/tvalid out, tready in)
// Purely combinational; the unselected source is always stalled.
// ---------------------------------------------------------------------------
module axis_mux2 #(
    parameter int DATA_W = 32
) (
    input  logic              en,
    input  logic              sel,
    input  logic [DATA_W-1:0] s0_tdata,
    input  logic              s0_tvalid,
    output logic              s0_tready,
    input  logic [DATA_W-1:0] s1_tdata,
    input  logic              s1_tvalid,
    output logic              s1_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready
);

    assign m_tdata   = sel ? s1_tdata : s0_tdata;
    assign m_tvalid  = en & (sel ? s1_tvalid : s0_tvalid);
    assign s0_tready = en & ~sel & m_tready;
    assign s1_tready = en &  sel & m_tready;

endmodule

// File: rtl/hist_run_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// hist_run_ctrl
// Sequences one histogram run: clear the bin RAM, forward num_samples LFSR
// samples to the histogram, pass the histogram's RAM writes through, then
// pulse done.
//   aclk, aresetn       : clock, asynchronous active-low reset
//   start, abort        : run request pulse / synchronous abort
//   num_samples         : samples per run, captured when start is accepted
//   busy, done          : run in progress / one-cycle completion pulse
//   hist_clr_n          : low while the RAM is being cleared
//   s_axis_lfsr_*       : LFSR sample stream in
//   m_axis_h_*          : samples out to the histogram
//   s_axis_h_*          : histogram RAM-write stream in
//   m_axis_ram_*        : AXI RAM write stream out
// All stream outputs are decoded from registered state, so reset forces every
// valid/ready output low immediately.
// ---------------------------------------------------------------------------
module hist_run_ctrl
    import hist_pkg::*;
#(
    parameter logic [7:0] CLR_LAST = 8'hFF,
    parameter int         NS_W     = 16
) (
    input  logic            aclk,
    input  logic            aresetn,
    input  logic            start,
    input  logic            abort,
    input  logic [NS_W-1:0] num_samples,
    output logic            busy,
    output logic            done,
    output logic            hist_clr_n,
    input  logic [31:0]     s_axis_lfsr_tdata,
    input  logic            s_axis_lfsr_tvalid,
    output logic            s_axis_lfsr_tready,
    output logic [31:0]     m_axis_h_tdata,
    output logic            m_axis_h_tvalid,
    input  logic            m_axis_h_tready,
    input  logic [31:0]     s_axis_h_tdata,
    input  logic            s_axis_h_tvalid,
    output logic            s_axis_h_tready,
    output logic [31:0]     m_axis_ram_tdata,
    output logic            m_axis_ram_tvalid,
    input  logic            m_axis_ram_tready
);

    hist_state_e     state_q, state_d;
    logic [NS_W-1:0] n_q, n_d;
    logic [NS_W-1:0] smp_cnt_q, smp_cnt_d;
    logic [NS_W:0]   wr_cnt_q, wr_cnt_d;     // one extra bit: 2*N never wraps
    logic [7:0]      clr_addr_q, clr_addr_d;

    logic in_clear, in_pass, run_fwd;
    logic clr_tready, clr_hs, wr_hs, smp_hs;

    assign in_clear = (state_q == ST_CLEAR);
    assign in_pass  = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    // smp_cnt only ever climbs to N, so N = all-ones is reached without wrap.
    assign run_fwd  = (state_q == ST_RUN) && (smp_cnt_q < n_q);

    assign busy       = in_clear || in_pass;
    assign done       = (state_q == ST_DONE);
    assign hist_clr_n = ~in_clear;

    // Sample path: the LFSR only advances while this run still needs samples.
    assign m_axis_h_tdata     = s_axis_lfsr_tdata;
    assign m_axis_h_tvalid    = run_fwd & s_axis_lfsr_tvalid;
    assign s_axis_lfsr_tready = run_fwd & m_axis_h_tready;

    axis_mux2 #(.DATA_W(32)) u_ram_mux (
        .en        (busy),
        .sel       (in_pass),
        .s0_tdata  (pack_ram_word(clr_addr_q, 8'h00)),
        .s0_tvalid (1'b1),
        .s0_tready (clr_tready),
        .s1_tdata  (s_axis_h_tdata),
        .s1_tvalid (s_axis_h_tvalid),
        .s1_tready (s_axis_h_tready),
        .m_tdata   (m_axis_ram_tdata),
        .m_tvalid  (m_axis_ram_tvalid),
        .m_tready  (m_axis_ram_tready)
    );

    // The clear source is always valid, so its ready is its handshake.
    assign clr_hs = clr_tready;
    assign wr_hs  = s_axis_h_tready & s_axis_h_tvalid;
    assign smp_hs = m_axis_h_tvalid & m_axis_h_tready;

    always_comb begin
        // NOTE: every next-state value defaults to its current value first, so
        // no path through the case leaves a signal unassigned (no latches).
        state_d    = state_q;
        n_d        = n_q;
        smp_cnt_d  = smp_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        clr_addr_d = clr_addr_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    n_d        = num_samples;
                    smp_cnt_d  = '0;
                    wr_cnt_d   = '0;
                    clr_addr_d = '0;
                    state_d    = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (clr_hs) begin
                    clr_addr_d = clr_addr_q + 8'd1;
                    if (clr_addr_q == CLR_LAST) begin
                        state_d = (n_q != '0) ? ST_RUN : ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                if (smp_hs) smp_cnt_d = smp_cnt_q + 1'b1;
                if (wr_hs)  wr_cnt_d  = wr_cnt_q + 1'b1;
                if (smp_cnt_q == n_q) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (wr_hs) wr_cnt_d = wr_cnt_q + 1'b1;
                // Each sample produces two RAM writes: bin count, then value.
                if (wr_cnt_q == {n_q, 1'b0}) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Abort overrides the transition only; handshakes on this edge still
        // count because the stream signals above were already exchanged.
        if (abort && busy) state_d = ST_IDLE;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= ST_IDLE;
            n_q        <= '0;
            smp_cnt_q  <= '0;
            wr_cnt_q   <= '0;
            clr_addr_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q    <= state_d;
            n_q        <= n_d;
            smp_cnt_q  <= smp_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            clr_addr_q <= clr_addr_d;
        end
    end

endmodule

// File: doc/hist_run_ctrl.md
HIST_RUN_CTRL -- requirements
Module: hist_run_ctrl

Interface
REQ-001 Parameter CLR_LAST, default 8'hFF, last RAM byte address zeroed in CLEAR.
REQ-002 Parameter NS_W, default 16, width of sample-count request.
REQ-003 aclk  in  1  single clock; all logic rising-edge.
REQ-004 aresetn  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  run request, one-cycle pulse.
REQ-006 abort  in  1  synchronous abort of any run.
REQ-007 num_samples  in  NS_W  samples per run, captured on accepted start.
REQ-008 busy  out  1  high in CLEAR, RUN and DRAIN.
REQ-009 done  out  1  one-cycle pulse on run completion.
REQ-010 hist_clr_n  out  1  low in CLEAR; top ANDs it into the histogram reset.
REQ-011 s_axis_lfsr_tdata/tvalid/tready  in/in/out  32/1/1  LFSR sample stream.
REQ-012 m_axis_h_tdata/tvalid/tready  out/out/in  32/1/1  samples to histogram.
REQ-013 s_axis_h_tdata/tvalid/tready  in/in/out  32/1/1  histogram RAM-write stream.
REQ-014 m_axis_ram_tdata/tvalid/tready  out/out/in  32/1/1  AXI RAM write stream, word = {8'h0, addr[7:0], 8'h0, data[7:0]}.

Function
REQ-015 The block SHALL implement states IDLE, CLEAR, RUN, DRAIN, DONE.
REQ-016 IDLE: start=1 SHALL capture num_samples, clear counters, set clr_addr=0, and enter CLEAR; start is ignored in all other states.
REQ-017 CLEAR: the block SHALL drive m_axis_ram_tdata={8'h0, clr_addr, 16'h0} with tvalid=1 held until handshake, and increment clr_addr per handshake.
REQ-018 On the handshake with clr_addr==CLR_LAST, the next state SHALL be RUN when N!=0 and DONE when N==0.
REQ-019 RUN, while smp_cnt<N: m_axis_h_tdata=s_axis_lfsr_tdata, m_axis_h_tvalid=s_axis_lfsr_tvalid, s_axis_lfsr_tready=m_axis_h_tready, all combinational; smp_cnt increments per handshake.
REQ-020 When smp_cnt==N, or in any state other than RUN, m_axis_h_tvalid and s_axis_lfsr_tready SHALL be 0, so the LFSR stalls.
REQ-021 RUN and DRAIN: m_axis_ram SHALL pass s_axis_h through combinationally (tdata, tvalid forward; tready back); wr_cnt (NS_W+1 bits) increments per RAM handshake.
REQ-022 In IDLE, CLEAR and DONE, s_axis_h_tready SHALL be 0; m_axis_ram_tvalid SHALL be 0 outside CLEAR, RUN and DRAIN.
REQ-023 RUN SHALL go to DRAIN on the cycle after smp_cnt reaches N.
REQ-024 DRAIN SHALL go to DONE when wr_cnt==2*N (two RAM writes per sample: count, then value).
REQ-025 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-026 abort=1 in CLEAR, RUN or DRAIN SHALL go to IDLE next cycle without a done pulse; abort has priority over every other transition.
REQ-027 A handshake and abort on the same edge SHALL complete the handshake before the controller enters IDLE.
REQ-028 Counters SHALL NOT wrap; N=max (2^NS_W-1) SHALL be fully supported.

Reset
REQ-029 On aresetn low, asynchronously: state=IDLE, busy=0, done=0, hist_clr_n=1, and all counters zeroed.
REQ-030 On aresetn low, asynchronously, all registered tvalid/tready outputs SHALL be 0.
REQ-031 Reset mid-run SHALL discard the run; the next start SHALL re-clear the RAM.

Structure
REQ-032 Shared package hist_pkg SHALL hold the state enum, the RAM word-packing field positions, and HIST_NUM_BINS=8.
REQ-033 One sub-module, axis_mux2, SHALL select between the CLEAR source and s_axis_h onto m_axis_ram; all other logic is flat.

Verification
REQ-034 Reset, then start with N=4 and tready always 1 -> 256 CLEAR words (addr 0x00..0xFF, data 0), then 4 samples forwarded, 8 RAM writes passed, done pulse once, busy low after DONE.
REQ-035 start with N=0 -> 256 CLEAR words, then DONE with no LFSR handshake.
REQ-036 N=3 with m_axis_ram_tready toggling 1/0 -> tdata stable while stalled, no lost or duplicated words, wr_cnt=6 at done.
REQ-037 abort asserted in RUN after 2 of N=5 samples -> IDLE next cycle, no done, s_axis_lfsr_tready=0.
REQ-038 start pulsed during RUN -> ignored, and the run completes with the original N.
REQ-039 aresetn dropped mid-CLEAR at addr 0x40 -> outputs at reset values immediately; the next start restarts clearing at 0x00.
